// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory slave: FSM states, response codes
// and the byte-offset width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  // Number of low address bits that select a byte within one data word.
  function automatic int offset_width(input int data_width);
    return (data_width <= 8) ? 0 : $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between the bridge (master) and a memory slave.
//
// Handshake: a transfer starts with one setup cycle (psel=1, penable=0),
// then holds psel=1, penable=1 and all request fields stable until the
// slave raises pready; the transfer completes on the rising pclk edge where
// psel & penable & pready are all 1. pslverr and prdata are only meaningful
// in that completing cycle.
interface apb_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) ();

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_strb_mem.sv
// Word-organised storage with per-byte-lane write strobes, a combinational
// read port, and reset initialisation of every word to its own index.
module apb_strb_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]           ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset loads word i with i; otherwise strobed lanes take the write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_WIDTH'(i);
    end else if (we && ({1'b0, widx} < (AW+1)'(DEPTH))) begin
      for (int b = 0; b < LANES; b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Indices past DEPTH read as zero rather than an undefined word.
  always_comb begin
    rdata = '0;
    if ({1'b0, ridx} < (AW+1)'(DEPTH)) rdata = mem[ridx];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: setup/wait/access FSM, wait-state counter, address
// decode with error response, and the registered read-data path.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_mem_slave_if.slave       bus,
  output apb_state_e           dbg_state
);

  localparam int OFF_W  = offset_width(DATA_WIDTH);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

  apb_state_e            state;
  logic [3:0]            cnt;
  logic [MEM_AW-1:0]     lat_idx;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [LANES-1:0]      lat_strb;
  logic                  lat_err;
  logic [DATA_WIDTH-1:0] prdata_q;

  logic [IDX_W-1:0]      idx;
  logic                  addr_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address decode on the live bus: word index, misalignment and range check.
  assign idx      = bus.paddr[ADDR_WIDTH-1:OFF_W];
  assign addr_err = (|(bus.paddr & OFF_MASK)) || ({1'b0, idx} >= (IDX_W+1)'(DEPTH));

  // Commit only in a genuine access cycle of a non-error write.
  assign mem_we = (state == ACCESS) && bus.psel && bus.penable &&
                  lat_write && (lat_err == RESP_OKAY);

  apb_strb_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (MEM_AW)
  ) u_mem (
    .clk  (pclk),
    .rst  (preset),
    .we   (mem_we),
    .widx (lat_idx),
    .wdata(lat_wdata),
    .wstrb(lat_strb),
    .ridx (idx[MEM_AW-1:0]),
    .rdata(mem_rdata)
  );

  // Transfer FSM with request latches, wait counter and read-data register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      lat_err   <= RESP_OKAY;
      prdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            lat_idx   <= idx[MEM_AW-1:0];
            lat_write <= bus.pwrite;
            lat_wdata <= bus.pwdata;
            lat_strb  <= bus.pstrb;
            lat_err   <= addr_err ? RESP_ERROR : RESP_OKAY;
            cnt       <= 4'(WAIT_STATES);
            if (!bus.pwrite) prdata_q <= addr_err ? '0 : mem_rdata;
            state     <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.penable) begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) state <= ACCESS;
          end
        end
        ACCESS:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pready  = (state == ACCESS);
  assign bus.pslverr = (state == ACCESS) ? lat_err : RESP_OKAY;
  assign bus.prdata  = prdata_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (0, 2 and 3 wait states)
// share one driver; a select picks which instance sees psel and is observed.
module tb_apb_mem_slave;
  import apb_pkg::*;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- shared driver signals ----------------
  int          sel = 0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus0 ();
  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus1 ();
  apb_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus2 ();
  apb_state_e st0, st1, st2;

  assign bus0.psel = psel & (sel == 0);
  assign bus1.psel = psel & (sel == 1);
  assign bus2.psel = psel & (sel == 2);
  assign bus0.penable = penable; assign bus1.penable = penable; assign bus2.penable = penable;
  assign bus0.pwrite  = pwrite;  assign bus1.pwrite  = pwrite;  assign bus2.pwrite  = pwrite;
  assign bus0.paddr   = paddr;   assign bus1.paddr   = paddr;   assign bus2.paddr   = paddr;
  assign bus0.pwdata  = pwdata;  assign bus1.pwdata  = pwdata;  assign bus2.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;   assign bus1.pstrb   = pstrb;   assign bus2.pstrb   = pstrb;

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(2)) dut_ws2 (
    .pclk(pclk), .preset(preset), .bus(bus0.slave), .dbg_state(st0));
  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) dut_ws0 (
    .pclk(pclk), .preset(preset), .bus(bus1.slave), .dbg_state(st1));
  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_STATES(3)) dut_ws3 (
    .pclk(pclk), .preset(preset), .bus(bus2.slave), .dbg_state(st2));

  // Observed outputs of the selected instance.
  logic        m_pready, m_pslverr;
  logic [31:0] m_prdata;
  apb_state_e  m_state;
  always_comb begin
    m_pready = bus0.pready; m_pslverr = bus0.pslverr; m_prdata = bus0.prdata; m_state = st0;
    case (sel)
      1: begin m_pready = bus1.pready; m_pslverr = bus1.pslverr; m_prdata = bus1.prdata; m_state = st1; end
      2: begin m_pready = bus2.pready; m_pslverr = bus2.pslverr; m_prdata = bus2.prdata; m_state = st2; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); preset = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  // One complete transfer; returns the completing-cycle outputs.
  task automatic xfer(input int s, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er,
                      output int waits, output int done_cyc);
    @(negedge pclk);
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    while (m_pready !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge pclk);
    end
    rd = m_prdata; er = m_pslverr; done_cyc = cyc;
    if (m_pready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL xfer_timeout: pready never rose for addr 0x%02h", addr);
    end
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          sel;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          exp_waits;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [12];

  logic [31:0] rd, rd2;
  logic        er, er2;
  int          w, w2, dc, dc2;
  string       nm;

  initial begin
    vt[0]  = '{0, 1'b0, 8'h0C, 32'h0,        4'h0, 2, 32'h00000003, 1'b0}; // reset value, 2 waits
    vt[1]  = '{1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
    vt[2]  = '{1, 1'b1, 8'h10, 32'h000000AA, 4'h1, 0, 32'h0,        1'b0};
    vt[3]  = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 0, 32'hDEADBEAA, 1'b0};
    vt[4]  = '{1, 1'b0, 8'h40, 32'h0,        4'h0, 0, 32'h00000000, 1'b1}; // index 16
    vt[5]  = '{1, 1'b1, 8'h02, 32'h00000055, 4'hF, 0, 32'h0,        1'b1}; // misaligned
    vt[6]  = '{1, 1'b0, 8'h00, 32'h0,        4'h0, 0, 32'h00000000, 1'b0};
    vt[7]  = '{1, 1'b1, 8'h20, 32'hCAFEF00D, 4'h6, 0, 32'h0,        1'b0}; // middle lanes
    vt[8]  = '{1, 1'b0, 8'h20, 32'h0,        4'h0, 0, 32'h00FEF008, 1'b0};
    vt[9]  = '{1, 1'b1, 8'h24, 32'hFFFFFFFF, 4'h0, 0, 32'h0,        1'b0}; // no strobes
    vt[10] = '{1, 1'b0, 8'h24, 32'h0,        4'h0, 0, 32'h00000009, 1'b0};
    vt[11] = '{2, 1'b0, 8'h3C, 32'h0,        4'h0, 3, 32'h0000000F, 1'b0}; // last word, 3 waits

    do_reset();

    // Reset state of every instance.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("rst_pready_%0d", s),  32'(m_pready), 32'h0);
      check($sformatf("rst_pslverr_%0d", s), 32'(m_pslverr), 32'h0);
      check($sformatf("rst_prdata_%0d", s),  m_prdata, 32'h0);
      check($sformatf("rst_state_%0d", s),   32'(m_state), 32'(IDLE));
    end

    // penable without a setup phase must be ignored (write to 0x00 never lands).
    @(negedge pclk);
    sel = 1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge pclk);
      check($sformatf("noset_pready_%0d", k), 32'(m_pready), 32'h0);
      check($sformatf("noset_state_%0d", k),  32'(m_state), 32'(IDLE));
    end
    psel = 1'b0; penable = 1'b0;

    // Table-driven transfers.
    for (int i = 0; i < 12; i++) begin
      xfer(vt[i].sel, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].st, rd, er, w, dc);
      check($sformatf("vec%0d_waits", i), 32'(w), 32'(vt[i].exp_waits));
      check($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vt[i].exp_err));
      if (!vt[i].wr) check($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rd);
    end

    // Back-to-back write then read with zero wait states.
    xfer(1, 1'b1, 8'h08, 32'h12345678, 4'hF, rd, er, w, dc);
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, rd2, er2, w2, dc2);
    check("b2b_write_waits", 32'(w), 32'h0);
    check("b2b_read_waits", 32'(w2), 32'h0);
    check("b2b_gap_cycles", 32'(dc2 - dc), 32'd2);
    check("b2b_prdata", rd2, 32'h12345678);

    // Abort a write in WAIT on the 3-wait-state instance.
    @(negedge pclk);
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    check("abort_state_wait", 32'(m_state), 32'(WAIT));
    check("abort_pready_a", 32'(m_pready), 32'h0);
    @(negedge pclk);
    check("abort_pready_b", 32'(m_pready), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("abort_state_idle", 32'(m_state), 32'(IDLE));
    check("abort_pready_c", 32'(m_pready), 32'h0);
    xfer(2, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, w, dc);
    check("abort_readback", rd, 32'h00000001);

    // Reset asserted mid-transfer (WAIT) on the 3-wait-state instance.
    xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er, w, dc);
    check("pre_rst_prdata", rd, 32'h00000003);
    @(negedge pclk);
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    check("midrst_state_wait", 32'(m_state), 32'(WAIT));
    #2 preset = 1'b1;
    #1;
    check("midrst_state", 32'(m_state), 32'(IDLE));
    check("midrst_pready", 32'(m_pready), 32'h0);
    check("midrst_pslverr", 32'(m_pslverr), 32'h0);
    check("midrst_prdata", m_prdata, 32'h0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    xfer(2, 1'b0, 8'h14, 32'h0, 4'h0, rd, er, w, dc);
    nm = "midrst_readback";
    check(nm, rd, 32'h00000005);
    check("midrst_read_waits", 32'(w), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB4 memory-mapped slave: a word-organised register/memory array with byte strobes, configurable wait states and error response. It sits on the peripheral bus behind the APB bridge as the generic storage target for configuration and scratch data. It generalises the earlier fixed-size, zero-wait slave in width, depth and timing, and adds `pslverr` and `pstrb` support.

## Interface

- `DATA_WIDTH`, 32: data bus width in bits; multiple of 8.
- `ADDR_WIDTH`, 8: byte address width.
- `DEPTH`, 64: number of words; must be ≤ 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- `WAIT_STATES`, 0: access-phase cycles with `pready` low before completion; 0 to 15.
- `pclk` input, 1: clock; all state updates on the rising edge.
- `preset` input, 1: asynchronous reset, active-high.
- `psel` input, 1: slave select.
- `penable` input, 1: access phase indicator.
- `pwrite` input, 1: 1 = write, 0 = read.
- `paddr` input, ADDR_WIDTH: byte address.
- `pwdata` input, DATA_WIDTH: write data.
- `pstrb` input, DATA_WIDTH/8: byte write strobes.
- `pready` output, 1: transfer completes in this cycle.
- `prdata` output, DATA_WIDTH: read data.
- `pslverr` output, 1: error response, valid only while `pready` = 1.

## Operation

- Word index = `paddr >> log2(DATA_WIDTH/8)`. Address error = index ≥ DEPTH, or any low (byte-offset) address bit nonzero.
- **IDLE**
  - On `psel` & !`penable`: latch address, `pwrite`, `pwdata`, `pstrb`, and the error flag.
  - Load the wait counter with WAIT_STATES.
  - For a read, register `prdata` = mem[index], or 0 on error.
  - Go to WAIT if WAIT_STATES > 0, else ACCESS.
  - In every other IDLE cycle, `prdata` holds its last value.
- **WAIT**
  - Decrement the counter each cycle while `psel` & `penable`.
  - Go to ACCESS when the counter reaches 1.
  - If `psel` drops, go to IDLE. The transfer is aborted and there is no write.
- **ACCESS**
  - `pready` = 1; `pslverr` = latched error.
  - On that edge, a non-error write updates each byte lane whose `pstrb` bit is 1. `pstrb` = 0 completes with OKAY and no change.
  - An error write leaves memory unchanged.
  - Next state is always IDLE.
  - If `psel` drops in ACCESS, go to IDLE with no write.
- `pready` and `pslverr` are decoded from state: 0 in IDLE and WAIT.
- Reads ignore `pstrb`.
- `penable` high in IDLE without a preceding setup phase is ignored; the block stays in IDLE.
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE; `pready` = 0, `pslverr` = 0, `prdata` = 0.
  - Every word i is initialised to value i (zero-extended).

## Timing

- Transfer length = 2 + WAIT_STATES cycles: 1 setup cycle, then WAIT_STATES cycles with `pready` = 0, then 1 cycle with `pready` = 1.
- `prdata` is stable from the first access-phase cycle until the next setup phase.
- A write becomes visible to a read whose setup phase is in the cycle after completion.
- Back-to-back transfers (setup immediately following completion) run with no idle gap.
- `pslverr` and `pready` change only on `pclk` edges or asynchronously on `preset`.

## Structure

- Shared package `apb_pkg`: `apb_state_e` {IDLE, WAIT, ACCESS}, OKAY/ERROR response constants, and a function for the byte-offset width.
- Sub-module `apb_strb_mem` holds the DEPTH × DATA_WIDTH array. It provides per-lane strobe writes, a combinational read port and reset initialisation.
- The top level holds the FSM, the wait counter, address decode and output registers.

## Test plan

All scenarios use DATA_WIDTH = 32, ADDR_WIDTH = 8 and DEPTH = 16.

- **Reset read, WAIT_STATES = 2:** reset, then read `paddr` = 0x0C → `pready` low for 2 access cycles and high on the 3rd; `prdata` = 0x00000003, `pslverr` = 0.
- **Byte strobes:** write 0xDEADBEEF to 0x10 with `pstrb` = 4'b1111, then 0x000000AA with `pstrb` = 4'b0001, then read 0x10 → `prdata` = 0xDEADBEAA.
- **Address errors:**
  - Read 0x40 (index 16) → `pslverr` = 1, `prdata` = 0.
  - Write 0x55 to 0x02 (misaligned) → `pslverr` = 1; a read of 0x00 returns 0x00000000.
- **Back-to-back, WAIT_STATES = 0:** write 0x12345678 to 0x08, immediately followed by a read of 0x08 → each transfer takes 2 cycles and the read returns 0x12345678.
- **Abort, WAIT_STATES = 3:** deassert `psel` during WAIT of a write to 0x04 → FSM returns to IDLE, no `pready`; a read of 0x04 returns 0x00000001.
- **Reset mid-transfer:** assert `preset` during WAIT of a write to 0x14 → `pready` = 0 immediately, state IDLE; after release, a read of 0x14 returns 0x00000005.
